// File: rtl/mmio_pkg.sv
// mmio_pkg: register map shared by the timer RTL, the core address map and
// the bench. Holds the word offsets inside the 8-word timer window and the
// bit positions of the CTRL and STATUS fields.
package mmio_pkg;

  // Word offsets within the timer window (realaddr[2:0]); 5-7 are reserved.
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd1;
  localparam logic [2:0] OFF_COUNT    = 3'd2;
  localparam logic [2:0] OFF_COMPARE  = 3'd3;
  localparam logic [2:0] OFF_STATUS   = 3'd4;

  // CTRL bit positions.
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;

  // STATUS bit positions.
  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;

  // COMPARE comes out of reset at all-ones so a freshly reset, enabled timer
  // only matches after a full count.
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_prescaler.sv
// mmio_prescaler: divides the clock by (limit + 1) while enabled.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset
//   en     in  count enable; counter holds while low
//   limit  in  terminal count; limit = 0 ticks every enabled cycle
//   clr    in  synchronous clear of the internal counter (wins over counting)
//   tick   out one-cycle pulse in the cycle where the counter equals limit
module mmio_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr,
  output logic             tick
);

  logic [WIDTH-1:0] pcnt_q;

  // The tick is combinational so the timer reacts in the same cycle the
  // prescaler reaches its terminal count.
  assign tick = en && (pcnt_q == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q <= '0;
    end else if (clr) begin
      pcnt_q <= '0;
    end else if (en) begin
      pcnt_q <= tick ? '0 : pcnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped 32-bit timer with prescaler, compare match,
// overflow flag and interrupt. Sits on the core bus next to memory; when
// rvalid is high the core's din mux takes rdata instead of memory data.
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   W         in   1 = write, 0 = read
//   realaddr  in   core word address; window is BASE_ADDR[15:3]
//   dout      in   core write data
//   rdata     out  read data, one cycle after the request; 0 when idle
//   rvalid    out  rdata holds a timer read response
//   irq       out  registered interrupt request
module mmio_timer
  import mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter int          PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W,
  input  logic [15:0] realaddr,
  input  logic [31:0] dout,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  logic [2:0]            ctrl_q,     ctrl_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [31:0]           count_q,    count_d;
  logic [31:0]           compare_q,  compare_d;
  logic                  match_q,    match_d;
  logic                  ovf_q,      ovf_d;
  logic                  rvalid_q,   rvalid_d;
  logic [31:0]           rdata_q,    rdata_d;
  logic                  irq_q,      irq_d;

  logic       hit, wr, rd;
  logic [2:0] off;
  logic       wr_ctrl, wr_presc, wr_count, wr_compare, wr_status;
  logic       tick, match_set, ovf_set;
  logic [31:0] rd_word;

  assign hit = (realaddr[15:3] == BASE_ADDR[15:3]);
  assign off = realaddr[2:0];
  assign wr  = hit && W;
  assign rd  = hit && !W;

  assign wr_ctrl    = wr && (off == OFF_CTRL);
  assign wr_presc   = wr && (off == OFF_PRESCALE);
  assign wr_count   = wr && (off == OFF_COUNT);
  assign wr_compare = wr && (off == OFF_COMPARE);
  assign wr_status  = wr && (off == OFF_STATUS);

  // Restart the prescale period whenever software reloads COUNT or PRESCALE.
  mmio_prescaler #(.WIDTH(PRESCALE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .limit (prescale_q),
    .clr   (wr_count || wr_presc),
    .tick  (tick)
  );

  always_comb begin
    ctrl_d     = ctrl_q;
    prescale_d = prescale_q;
    count_d    = count_q;
    compare_d  = compare_q;
    match_set  = 1'b0;
    ovf_set    = 1'b0;

    if (tick) begin
      if (count_q == compare_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[CTRL_AR] ? 32'd0 : count_q + 32'd1;
      end else if (count_q == 32'hFFFF_FFFF) begin
        ovf_set = 1'b1;
        count_d = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    // Software writes come last so a COUNT write beats the tick update.
    if (wr_ctrl)    ctrl_d     = dout[2:0];
    if (wr_presc)   prescale_d = dout[PRESCALE_W-1:0];
    if (wr_count)   count_d    = dout;
    if (wr_compare) compare_d  = dout;

    // Write-1-to-clear, with a same-cycle hardware set taking priority.
    match_d = match_set | (match_q & ~(wr_status & dout[ST_MATCH]));
    ovf_d   = ovf_set   | (ovf_q   & ~(wr_status & dout[ST_OVF]));

    // Built from next-state values so irq lands on the same edge as the flag.
    irq_d = ctrl_d[CTRL_IE] & (match_d | ovf_d);

    rd_word = 32'd0;
    case (off)
      OFF_CTRL: begin
        rd_word[CTRL_EN] = ctrl_q[CTRL_EN];
        rd_word[CTRL_AR] = ctrl_q[CTRL_AR];
        rd_word[CTRL_IE] = ctrl_q[CTRL_IE];
      end
      OFF_PRESCALE: rd_word[PRESCALE_W-1:0] = prescale_q;
      OFF_COUNT:    rd_word = count_q;
      OFF_COMPARE:  rd_word = compare_q;
      OFF_STATUS: begin
        rd_word[ST_MATCH] = match_q;
        rd_word[ST_OVF]   = ovf_q;
      end
      default:      rd_word = 32'd0;
    endcase

    rvalid_d = rd;
    rdata_d  = rd ? rd_word : 32'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      count_q    <= '0;
      compare_q  <= COMPARE_RST;
      match_q    <= 1'b0;
      ovf_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      prescale_q <= prescale_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      match_q    <= match_d;
      ovf_q      <= ovf_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: self-checking bench for mmio_timer. Every bus cycle pushes
// the expected read response onto a scoreboard; a checker pops it one cycle
// later and compares rvalid/rdata. Register access is table driven, the
// timer scenarios are hand-written cycle sequences.
module tb_mmio_timer;
  import mmio_pkg::*;

  localparam logic [15:0] BASE = 16'hFF00;
  localparam logic [15:0] MISS = 16'h0010;

  logic        clk;
  logic        reset;
  logic        W;
  logic [15:0] realaddr;
  logic [31:0] dout;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [31:0] d;
  } exp_t;

  exp_t  sb[$];
  string sb_nm[$];

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [31:0] d;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t vt[$];

  mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .W        (W),
    .realaddr (realaddr),
    .dout     (dout),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] A(input logic [2:0] off);
    A = {BASE[15:3], off};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  // Response checker: one scoreboard entry per driven cycle, checked just
  // after the edge that registers the response.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb.pop_front();
      nm = sb_nm.pop_front();
      $display("txn %s: rvalid=%0b rdata=%08h (want %0b %08h)", nm, rvalid, rdata, e.v, e.d);
      chk({nm, ".rvalid"}, 32'(rvalid), 32'(e.v));
      chk({nm, ".rdata"}, rdata, e.d);
    end
  end

  task automatic step(input logic w, input logic [15:0] a, input logic [31:0] d,
                      input logic ev, input logic [31:0] ed, input string nm);
    exp_t e;
    W        = w;
    realaddr = a;
    dout     = d;
    e.v = ev;
    e.d = ed;
    sb.push_back(e);
    sb_nm.push_back(nm);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input string nm);
    step(1'b1, A(off), d, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [2:0] off, input logic [31:0] ed, input string nm);
    step(1'b0, A(off), 32'h0, 1'b1, ed, nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, MISS, 32'h0, 1'b0, 32'h0, "idle");
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    W        = 1'b0;
    realaddr = MISS;
    dout     = 32'h0;

    // Reset state.
    @(posedge clk);
    #1;
    chk("rst.rvalid", 32'(rvalid), 32'h0);
    chk("rst.rdata", rdata, 32'h0);
    chk("rst.irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Reset values of the whole map.
    rd(OFF_CTRL,     32'h0,         "r0.ctrl");
    rd(OFF_PRESCALE, 32'h0,         "r0.prescale");
    rd(OFF_COUNT,    32'h0,         "r0.count");
    rd(OFF_COMPARE,  32'hFFFF_FFFF, "r0.compare");
    rd(OFF_STATUS,   32'h0,         "r0.status");

    // Register access with the timer stopped.
    vt.push_back('{1'b1, A(OFF_CTRL),     32'hFFFF_FFF6, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_CTRL),     32'h0,         1'b1, 32'h6});
    vt.push_back('{1'b1, A(OFF_PRESCALE), 32'h1234_5678, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_PRESCALE), 32'h0,         1'b1, 32'h78});
    vt.push_back('{1'b1, A(OFF_COMPARE),  32'hDEAD_BEEF, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_COMPARE),  32'h0,         1'b1, 32'hDEAD_BEEF});
    vt.push_back('{1'b1, A(OFF_COUNT),    32'h0000_1234, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_COUNT),    32'h0,         1'b1, 32'h0000_1234});
    vt.push_back('{1'b1, A(3'd5),         32'hFFFF_FFFF, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(3'd5),         32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b0, A(3'd7),         32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b1, 16'hFF08,        32'h0,         1'b0, 32'h0});
    vt.push_back('{1'b0, 16'hFF08,        32'h0,         1'b0, 32'h0});
    vt.push_back('{1'b0, 16'hFEFF,        32'h0,         1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_CTRL),     32'h0,         1'b1, 32'h6});
    vt.push_back('{1'b1, A(OFF_STATUS),   32'hFFFF_FFFF, 1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_STATUS),   32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b1, A(OFF_CTRL),     32'h0,         1'b0, 32'h0});
    vt.push_back('{1'b0, A(OFF_CTRL),     32'h0,         1'b1, 32'h0});
    vt.push_back('{1'b0, A(OFF_COUNT),    32'h0,         1'b1, 32'h0000_1234});
    for (int i = 0; i < vt.size(); i++)
      step(vt[i].w, vt[i].a, vt[i].d, vt[i].ev, vt[i].ed, $sformatf("vec%0d", i));
    chk("vec.irq", 32'(irq), 32'h0);

    // Prescale 3, compare 5, autoreload: sixth tick (cycle 24) matches.
    wr(OFF_PRESCALE, 32'd3, "m.presc");
    wr(OFF_COMPARE,  32'd5, "m.cmp");
    wr(OFF_COUNT,    32'd0, "m.cnt");
    wr(OFF_STATUS,   32'd3, "m.clr");
    wr(OFF_CTRL,     32'd7, "m.ctrl");
    idle(23);
    chk("match.irq_c24", 32'(irq), 32'h0);
    idle(1);
    chk("match.irq_c25", 32'(irq), 32'h1);
    rd(OFF_STATUS, 32'h1, "match.status");
    rd(OFF_COUNT,  32'h0, "match.count");
    wr(OFF_CTRL,   32'h0, "match.stop");
    wr(OFF_STATUS, 32'h1, "match.w1c");
    chk("match.irq_clr", 32'(irq), 32'h0);
    rd(OFF_STATUS, 32'h0, "match.status_clr");

    // Overflow: FFFFFFFE -> FFFFFFFF -> 0 with OVF, timer stopped right after.
    wr(OFF_PRESCALE, 32'd0,         "o.presc");
    wr(OFF_COMPARE,  32'd0,         "o.cmp");
    wr(OFF_COUNT,    32'hFFFF_FFFE, "o.cnt");
    wr(OFF_STATUS,   32'd3,         "o.clr");
    wr(OFF_CTRL,     32'd5,         "o.ctrl");
    idle(1);
    chk("ovf.irq_pre", 32'(irq), 32'h0);
    wr(OFF_CTRL,     32'd4,         "o.stop");
    chk("ovf.irq", 32'(irq), 32'h1);
    rd(OFF_STATUS, 32'h2, "ovf.status");
    rd(OFF_COUNT,  32'h0, "ovf.count");
    wr(OFF_STATUS, 32'h2, "ovf.w1c");
    chk("ovf.irq_clr", 32'(irq), 32'h0);
    rd(OFF_STATUS, 32'h0, "ovf.status_clr");

    // Clear of MATCH on the same edge the hardware sets it again.
    wr(OFF_CTRL,   32'd3, "s.ctrl");
    idle(1);
    wr(OFF_STATUS, 32'd1, "s.w1c_race");
    rd(OFF_STATUS, 32'h1, "set_wins.status");
    wr(OFF_CTRL,   32'd0, "s.stop");
    wr(OFF_STATUS, 32'd1, "s.w1c");
    rd(OFF_STATUS, 32'h0, "set_wins.status_clr");
    chk("set_wins.irq", 32'(irq), 32'h0);

    // COUNT write on a tick cycle overrides the increment.
    wr(OFF_COMPARE,  32'hFFFF_0000, "c.cmp");
    wr(OFF_PRESCALE, 32'd0,         "c.presc");
    wr(OFF_CTRL,     32'd1,         "c.ctrl");
    idle(2);
    wr(OFF_COUNT,    32'd100,       "c.cnt");
    rd(OFF_COUNT, 32'd100, "cwr.count");
    rd(OFF_COUNT, 32'd101, "cwr.count_next");
    wr(OFF_CTRL,     32'd0,         "c.stop");
    step(1'b1, MISS, 32'hFFFF_FFFF, 1'b0, 32'h0, "miss.wr");
    step(1'b0, MISS, 32'h0,         1'b0, 32'h0, "miss.rd");
    rd(OFF_CTRL, 32'h0, "miss.ctrl");

    // COUNT write restarts the prescale period.
    wr(OFF_PRESCALE, 32'd3,  "p.presc");
    wr(OFF_CTRL,     32'd1,  "p.ctrl");
    idle(2);
    wr(OFF_COUNT,    32'd50, "p.cnt");
    idle(3);
    rd(OFF_COUNT, 32'd50, "pclr.count_hold");
    rd(OFF_COUNT, 32'd51, "pclr.count_tick");
    wr(OFF_CTRL,     32'd0,  "p.stop");

    // Reset during a read response with the timer running and irq high.
    wr(OFF_PRESCALE, 32'd0, "r.presc");
    wr(OFF_COMPARE,  32'd0, "r.cmp");
    wr(OFF_COUNT,    32'd0, "r.cnt");
    wr(OFF_CTRL,     32'd7, "r.ctrl");
    idle(1);
    chk("rstmid.irq_pre", 32'(irq), 32'h1);
    W        = 1'b0;
    realaddr = A(OFF_COUNT);
    @(posedge clk);
    #1;
    chk("rstmid.rvalid_pre", 32'(rvalid), 32'h1);
    reset    = 1'b1;
    realaddr = MISS;
    #1;
    chk("rstmid.rvalid", 32'(rvalid), 32'h0);
    chk("rstmid.rdata", rdata, 32'h0);
    chk("rstmid.irq", 32'(irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid.rvalid_rel", 32'(rvalid), 32'h0);
    idle(1);
    rd(OFF_COUNT,   32'h0,         "rstmid.count");
    rd(OFF_COUNT,   32'h0,         "rstmid.count_hold");
    rd(OFF_CTRL,    32'h0,         "rstmid.ctrl");
    rd(OFF_COMPARE, 32'hFFFF_FFFF, "rstmid.compare");
    rd(OFF_STATUS,  32'h0,         "rstmid.status");
    chk("rstmid.irq_post", 32'(irq), 32'h0);

    idle(1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
